// File: rtl/vga_framebuffer_reader.sv
// vga_framebuffer_reader: 8-bit RRRGGGBB pixel source for the VGA timing driver.
// Holds a downscaled framebuffer in simple dual-port RAM, takes host pixel writes,
// and has a built-in engine that fills the whole buffer with one colour.
// Optional build macro FB_TEST_PATTERN_EN adds pattern_sel, which selects an
// XOR test pattern in place of RAM data.
module vga_framebuffer_reader #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  next_x,
    input  logic [9:0]  next_y,
    output logic [7:0]  color_out,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_x,
    input  logic [7:0]  wr_y,
    input  logic [7:0]  wr_color,
    input  logic        clear_start,
    input  logic [7:0]  clear_color,
    output logic        busy,
    output logic        clear_done,
    output logic        oob_flag
`ifdef FB_TEST_PATTERN_EN
    ,
    input  logic        pattern_sel
`endif
);

    localparam int FB_W    = H_RES >> SCALE_SHIFT;
    localparam int FB_H    = V_RES >> SCALE_SHIFT;
    localparam int FB_SIZE = FB_W * FB_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_clearCnt;
    logic [7:0]          r_clearColor;
    logic [7:0]          r_colorOut;
    logic                r_clearDone;
    logic                r_oobFlag;
    logic [7:0]          r_ram [0:FB_SIZE-1];

    logic [10:0]         w_lookX;
    logic [10:0]         w_col;
    logic [9:0]          w_row;
    logic                w_inActive;
    logic [ADDR_W-1:0]   w_readAddr;
    logic [7:0]          w_pattern;
    logic                w_hostInRange;
    logic [ADDR_W-1:0]   w_hostAddr;
    logic                w_wrEn;
    logic [ADDR_W-1:0]   w_wrAddr;
    logic [7:0]          w_wrData;
    logic                w_clearAccept;

    assign color_out  = r_colorOut;
    assign clear_done = r_clearDone;
    assign oob_flag   = r_oobFlag;

    // Read address: one-pixel lookahead (saturating at the last column) hides the RAM register.
    always_comb begin
        w_lookX = ({1'b0, next_x} >= 11'(H_RES - 1)) ? 11'(H_RES - 1) : ({1'b0, next_x} + 11'd1);
        w_col      = w_lookX >> SCALE_SHIFT;
        w_row      = next_y >> SCALE_SHIFT;
        w_inActive = (32'(next_y) < V_RES);
        w_readAddr = ADDR_W'(32'(w_row) * FB_W + 32'(w_col));
        w_pattern  = 8'(w_col ^ {1'b0, w_row});
    end

    // Host write decode: range check and linear address of the requested pixel.
    always_comb begin
        w_hostInRange = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
        w_hostAddr    = ADDR_W'(32'(wr_y) * FB_W + 32'(wr_x));
    end

    // Next-state and write-port arbitration: the host owns the port only while IDLE.
    always_comb begin
        w_nextState   = r_state;
        wr_ready      = 1'b0;
        busy          = 1'b0;
        w_wrEn        = 1'b0;
        w_wrAddr      = w_hostAddr;
        w_wrData      = wr_color;
        w_clearAccept = 1'b0;
        case (r_state)
            IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid && w_hostInRange) begin
                    w_wrEn = 1'b1;
                end
                if (clear_start) begin
                    w_clearAccept = 1'b1;
                    w_nextState   = CLEAR;
                end
            end
            CLEAR: begin
                busy     = 1'b1;
                w_wrEn   = 1'b1;
                w_wrAddr = r_clearCnt;
                w_wrData = r_clearColor;
                if (r_clearCnt == LAST_ADDR) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Fill address counter and colour latched from the accepted clear_start.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_clearCnt   <= '0;
            r_clearColor <= '0;
        end else if (w_clearAccept) begin
            r_clearCnt   <= '0;
            r_clearColor <= clear_color;
        end else if (r_state == CLEAR) begin
            r_clearCnt <= (r_clearCnt == LAST_ADDR) ? '0 : r_clearCnt + 1'b1;
        end
    end

    // Completion pulse in the cycle after the last fill write.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_clearDone <= 1'b0;
        end else begin
            r_clearDone <= (r_state == CLEAR) && (r_clearCnt == LAST_ADDR);
        end
    end

    // Sticky out-of-range flag; a new clear starts with it cleared.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_oobFlag <= 1'b0;
        end else if (w_clearAccept) begin
            r_oobFlag <= 1'b0;
        end else if ((r_state == IDLE) && wr_valid && !w_hostInRange) begin
            r_oobFlag <= 1'b1;
        end
    end

    // RAM write port; contents are never reset, and writes are held off during reset.
    always_ff @(posedge clock) begin
        if (w_wrEn && reset) begin
            r_ram[w_wrAddr] <= w_wrData;
        end
    end

    // Registered read port: old data on read-during-write, black outside the active lines.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_colorOut <= '0;
        end else if (!w_inActive) begin
            r_colorOut <= '0;
`ifdef FB_TEST_PATTERN_EN
        end else if (pattern_sel) begin
            r_colorOut <= w_pattern;
`endif
        end else begin
            r_colorOut <= r_ram[w_readAddr];
        end
    end

`ifndef FB_TEST_PATTERN_EN
    logic w_unusedPattern;
    assign w_unusedPattern = ^w_pattern;
`endif

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// tb_vga_framebuffer_reader: randomized self-checking bench for vga_framebuffer_reader.
// A flat array model of the 160x120 framebuffer predicts every pixel read.
module tb_vga_framebuffer_reader;

    localparam int FB_W    = 160;
    localparam int FB_H    = 120;
    localparam int FB_SIZE = FB_W * FB_H;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] next_x = '0;
    logic [9:0] next_y = '0;
    logic [7:0] color_out;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_x = '0;
    logic [7:0] wr_y = '0;
    logic [7:0] wr_color = '0;
    logic       clear_start = 1'b0;
    logic [7:0] clear_color = '0;
    logic       busy;
    logic       clear_done;
    logic       oob_flag;
    logic       patSel = 1'b0;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] model [0:FB_SIZE-1];
    bit         oobExp = 1'b0;

    vga_framebuffer_reader dut (
        .clock       (clock),
        .reset       (reset),
        .next_x      (next_x),
        .next_y      (next_y),
        .color_out   (color_out),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_color    (wr_color),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .busy        (busy),
        .clear_done  (clear_done),
        .oob_flag    (oob_flag)
`ifdef FB_TEST_PATTERN_EN
        ,
        .pattern_sel (patSel)
`endif
    );

    // 10 ns pixel clock stand-in.
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Pixel the driver should see one cycle after presenting (nx, ny).
    function automatic logic [7:0] expectedPixel(input int nx, input int ny, input bit pat);
        int lx;
        int col;
        int row;
        if (ny >= 480) return 8'h00;
        lx  = (nx + 1 > 639) ? 639 : nx + 1;
        col = lx / 4;
        row = ny / 4;
        if (pat) return 8'((col ^ row) & 255);
        return model[row * FB_W + col];
    endfunction

    task automatic readCheck(input string tag, input int nx, input int ny);
        next_x = 10'(nx);
        next_y = 10'(ny);
        @(posedge clock);
        #1;
        checkOutput(tag, 32'(color_out), 32'(expectedPixel(nx, ny, patSel)));
    endtask

    task automatic randomReads(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            readCheck(tag, int'($urandom_range(0, 1023)), int'($urandom_range(0, 524)));
        end
    endtask

    // Host pixel write through the valid/ready handshake.
    task automatic applyStimulus(input int x, input int y, input logic [7:0] c);
        int guard;
        guard = 0;
        while (!wr_ready && guard < 25000) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (!wr_ready) checkOutput("wrReadyTimeout", 32'(wr_ready), 32'(1));
        wr_valid = 1'b1;
        wr_x     = 8'(x);
        wr_y     = 8'(y);
        wr_color = c;
        @(posedge clock);
        #1;
        wr_valid = 1'b0;
        if (x < FB_W && y < FB_H) model[y * FB_W + x] = c;
        else oobExp = 1'b1;
    endtask

    // Full fill: measures busy length, wr_ready, and the single done pulse.
    task automatic runClear(input logic [7:0] color, input bit midPulse, input bit withWrite);
        int busyCycles;
        int doneCount;
        int readyBad;
        int lastBusy;
        int doneIdx;
        busyCycles = 0;
        doneCount  = 0;
        readyBad   = 0;
        lastBusy   = -1;
        doneIdx    = -1;
        clear_start = 1'b1;
        clear_color = color;
        if (withWrite) begin
            wr_valid = 1'b1;
            wr_x     = 8'd0;
            wr_y     = 8'd0;
            wr_color = 8'hFF;
        end
        @(posedge clock);
        #1;
        clear_start = 1'b0;
        wr_valid    = 1'b0;
        clear_color = 8'h5A;
        checkOutput("oobClearedByStart", 32'(oob_flag), 32'(0));
        oobExp = 1'b0;
        for (int cyc = 0; cyc < FB_SIZE + 10; cyc++) begin
            if (busy) begin
                busyCycles++;
                lastBusy = cyc;
                if (wr_ready) readyBad++;
            end
            if (clear_done) begin
                doneCount++;
                doneIdx = cyc;
            end
            if (midPulse && cyc == 50) begin
                clear_start = 1'b1;
                clear_color = 8'h55;
            end
            if (midPulse && cyc == 51) clear_start = 1'b0;
            @(posedge clock);
            #1;
        end
        checkOutput("clearBusyCycles", 32'(busyCycles), 32'(FB_SIZE));
        checkOutput("clearWrReadyLow", 32'(readyBad), 32'(0));
        checkOutput("clearDoneCount", 32'(doneCount), 32'(1));
        checkOutput("clearDoneAfterBusy", 32'(doneIdx), 32'(lastBusy + 1));
        for (int i = 0; i < FB_SIZE; i++) model[i] = color;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rstColorOut", 32'(color_out), 32'(0));
        checkOutput("rstBusy", 32'(busy), 32'(0));
        checkOutput("rstClearDone", 32'(clear_done), 32'(0));
        checkOutput("rstOob", 32'(oob_flag), 32'(0));
        checkOutput("rstWrReady", 32'(wr_ready), 32'(1));
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Known contents, then the single-pixel lookahead cases.
        runClear(8'h00, 1'b0, 1'b0);
        applyStimulus(3, 2, 8'hE0);
        readCheck("px11y8", 11, 8);
        readCheck("px12y8", 12, 8);
        readCheck("px15y8", 15, 8);
        readCheck("px10y8", 10, 8);

        // Random host writes, some out of range, then random reads.
        for (int i = 0; i < 150; i++) begin
            applyStimulus(int'($urandom_range(0, 170)), int'($urandom_range(0, 127)),
                          8'($urandom_range(0, 255)));
        end
        checkOutput("oobAfterRandom", 32'(oob_flag), 32'(oobExp));
        randomReads("rndRead", 300);

        // Out-of-range write leaves row 0 alone and sets the flag.
        applyStimulus(160, 0, 8'hAA);
        checkOutput("oobSet", 32'(oob_flag), 32'(1));
        readCheck("oobCol0", 0, 0);
        readCheck("oobCol1", 3, 0);
        readCheck("oobCol2", 7, 0);
        readCheck("oobCol3", 11, 0);

        // Fill with a stray clear_start in the middle; flag cleared by the start.
        runClear(8'h1C, 1'b1, 1'b0);
        randomReads("fill1C", 300);

        // Simultaneous host write and clear_start: the fill wins.
        runClear(8'h03, 1'b0, 1'b1);
        readCheck("px00After", 0, 0);

        // Blanking and saturation at the buffer edges.
        applyStimulus(0, 119, 8'hA1);
        applyStimulus(159, 119, 8'hB2);
        readCheck("blankX0", 0, 479);
        readCheck("satX639", 639, 479);
        readCheck("satX638", 638, 479);
        readCheck("satX1023", 1023, 479);
        readCheck("vblankY500", 639, 500);

`ifdef FB_TEST_PATTERN_EN
        patSel = 1'b1;
        readCheck("pattern19x4", 19, 4);
        randomReads("patternRnd", 50);
        patSel = 1'b0;
`endif

        // Reset during a fill: partial contents, no done pulse.
        applyStimulus(150, 0, 8'h77);
        clear_start = 1'b1;
        clear_color = 8'h99;
        @(posedge clock);
        #1;
        clear_start = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        checkOutput("abortBusyBefore", 32'(busy), 32'(1));
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        checkOutput("abortBusy", 32'(busy), 32'(0));
        checkOutput("abortColorOut", 32'(color_out), 32'(0));
        checkOutput("abortWrReady", 32'(wr_ready), 32'(1));
        begin
            int doneSeen;
            doneSeen = 0;
            for (int i = 0; i < 30; i++) begin
                if (clear_done) doneSeen++;
                @(posedge clock);
                #1;
            end
            checkOutput("abortNoDone", 32'(doneSeen), 32'(0));
        end
        for (int i = 0; i < 100; i++) model[i] = 8'h99;
        readCheck("abortAddr150", 599, 0);
        readCheck("abortAddr99", 395, 0);
        readCheck("abortAddr100", 399, 0);
        randomReads("abortRnd", 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
